seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode 7-segment display. It holds a 16-bit hex value and cycles through the digits, driving one active-low anode at a time together with the matching active-low segment pattern and decimal point. New values are double-buffered and applied only at frame boundaries, so a displayed frame never mixes old and new digits. It sits between the system's value producer and the board's anode and segment pins, and uses the same segment encoding as the team's anode decoder.

## Interface
- CLK_DIV, default 50000: clock cycles per digit slot; minimum legal value 2.
- CNT_W, default 16: width of the slot counter; must satisfy 2^CNT_W >= CLK_DIV.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture `value` and `dp_in` into the shadow registers this cycle.
- value  in  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  in  4  decimal point per digit, active-high; bit k belongs to digit k.
- blank  in  1  synchronous display blank; forces all anodes off.
- an  out  4  anode enables, active-low; an[k] selects digit k.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- busy  out  1  high while a loaded value is pending and not yet displayed.
- frame_done  out  1  one-cycle pulse on the last cycle of each full scan.

## Operation
- State:
  - slot counter `cnt` (0..CLK_DIV-1);
  - digit index `idx` (0..3);
  - display registers `disp[15:0]` and `disp_dp[3:0]`;
  - shadow registers `shd[15:0]` and `shd_dp[3:0]`;
  - `pending` flag.
- Scan sequencing:
  - `cnt` increments every clock.
  - At cnt == CLK_DIV-1, `cnt` wraps to 0 and `idx` advances 0→1→2→3→0.
- Ghost guard: in the cycle where cnt == 0, all anodes are high and seg = 7'b1111111.
- Active slot: for cnt 1..CLK_DIV-1, an has only bit `idx` low, and seg/dp show `disp[4*idx+:4]` and `disp_dp[idx]`.
- Segment encoding, active-low {a..g}:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
  - A = 0001000
  - b = 1100000
  - C = 0110001
  - d = 1000010
  - E = 0110000
  - F = 0111000
- Frame boundary: the cycle where idx == 3 and cnt == CLK_DIV-1.
- Load handling:
  - `load` writes `shd`/`shd_dp` and sets `pending`.
  - At a frame boundary with `pending` set, `disp` ← `shd` and `pending` clears.
- Simultaneous load and frame boundary: the incoming `value`/`dp_in` go straight into `disp` and `shd`, and `pending` stays 0.
- Back-to-back loads before a boundary: the last one wins.
- `blank` = 1:
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - Scanning, load and frame_done continue unaffected.
- Reset mid-scan aborts immediately; any pending value is discarded.

## Timing
- Reset values:
  - an = 4'b1111, seg = 7'b1111111, dp = 1;
  - busy = 0, frame_done = 0;
  - cnt = 0, idx = 0;
  - disp = shd = 0, disp_dp = shd_dp = 0, pending = 0.
- All outputs are registered, loaded from next-state decode so they are cycle-aligned with `cnt`/`idx`. There is no combinational path from inputs to outputs.
- After reset release:
  - 1st clock edge: cnt=0, guard cycle.
  - 2nd clock edge: an = 1110.
- Slot and frame length: each digit is lit for CLK_DIV-1 cycles; a frame is 4·CLK_DIV cycles.
- Load latency:
  - busy rises the cycle after `load`.
  - The new value is visible from the first active cycle of digit 0 in the next frame.
  - Worst case is 4·CLK_DIV+1 cycles.
- frame_done is high for exactly the frame-boundary cycle.
- `blank` affects outputs on the next clock edge.

## Configuration
- SEG_LZB_EN defined (leading-zero blanking):
  - Digits 3, 2, 1 whose nibble and every more-significant nibble are 0 keep their anode high during their slot.
  - Digit 0 is always shown.
  - A set `disp_dp` bit on a digit disables blanking for that digit and for all less-significant digits.
- SEG_LZB_EN undefined: all four digits are always lit, including leading zeros.

## Test plan
- Reset scan, CLK_DIV=4, no load:
  - Per-cycle an = 1111,1110,1110,1110, 1111,1101,1101,1101, 1111,1011, … , 1111,0111,0111,0111.
  - seg = 0000001 in all active cycles.
  - frame_done pulses at cycle 16 only.
- Load 16'h12AF, dp_in=4'b0100, mid digit 1:
  - busy goes high.
  - The current frame still shows 0s.
  - The next frame shows digit0 seg=0111000, digit1 0001000, digit2 0010010 with dp=0, digit3 1001111.
  - busy clears after the boundary.
- Load asserted exactly on the frame-boundary cycle with 16'h8888: busy never rises, and the next digit-0 slot shows 0000000.
- blank=1 for a full frame: an stays 1111 throughout, frame_done still pulses, and scanning resumes in phase after blank=0.
- rst_n pulled low mid-slot with a load pending: outputs return to reset values immediately, and the pending value never appears.
- With SEG_LZB_EN, load 16'h0042: an[3] and an[2] stay high during their slots, digit1 shows 1001100, and digit0 shows 0010010.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexing scan controller for a 4-digit common-anode 7-segment
// display. A 16-bit hex value is double-buffered: `load` captures it into a
// shadow register and it is promoted to the display register only at a frame
// boundary, so a single frame never mixes old and new digits.
//
// Each digit slot lasts CLK_DIV cycles. The first cycle of each slot
// (cnt == 0) is a ghost guard where every anode is off.
//
// Parameters:
//   CLK_DIV  clock cycles per digit slot (>= 2)
//   CNT_W    slot counter width, 2**CNT_W >= CLK_DIV
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        capture value/dp_in into the shadow registers
//   value       four hex digits, [3:0] = digit 0 (rightmost)
//   dp_in       decimal points per digit, active-high
//   blank       forces all anodes off (registered, takes effect next edge)
//   an          anode enables, active-low, an[k] = digit k
//   seg         segments {a,b,c,d,e,f,g}, active-low
//   dp          decimal point, active-low
//   busy        a loaded value is waiting for the next frame boundary
//   frame_done  one-cycle pulse on the last cycle of each frame
//
// Build option:
//   SEG_LZB_EN  when defined, leading-zero blanking of digits 3..1 is enabled;
//               a set decimal point on a digit keeps it and all lower digits lit
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       idx, idx_n;
    logic [15:0]      disp, disp_n, shd, shd_n;
    logic [3:0]       disp_dp, disp_dp_n, shd_dp, shd_dp_n;
    logic             pending, pending_n;
    logic             boundary, lit;
    logic [3:0]       an_n;
    logic [6:0]       seg_n;
    logic             dp_n, frame_done_n;

    // Hex nibble to active-low {a..g} pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'b0000001;
            4'h1:    hex_to_seg = 7'b1001111;
            4'h2:    hex_to_seg = 7'b0010010;
            4'h3:    hex_to_seg = 7'b0000110;
            4'h4:    hex_to_seg = 7'b1001100;
            4'h5:    hex_to_seg = 7'b0100100;
            4'h6:    hex_to_seg = 7'b0100000;
            4'h7:    hex_to_seg = 7'b0001111;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0000100;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b1100000;
            4'hC:    hex_to_seg = 7'b0110001;
            4'hD:    hex_to_seg = 7'b1000010;
            4'hE:    hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    // Next-state logic: slot/digit sequencing and the shadow-to-display
    // hand-over. A load landing exactly on the boundary bypasses the shadow
    // stage so nothing is left pending.
    always_comb begin
        cnt_n     = cnt + 1'b1;
        idx_n     = idx;
        shd_n     = shd;
        shd_dp_n  = shd_dp;
        disp_n    = disp;
        disp_dp_n = disp_dp;
        pending_n = pending;
        boundary  = (idx == 2'd3) && (cnt == LAST);

        if (cnt == LAST) begin
            cnt_n = '0;
            idx_n = idx + 2'd1;
        end

        if (load) begin
            shd_n    = value;
            shd_dp_n = dp_in;
            if (boundary) begin
                disp_n    = value;
                disp_dp_n = dp_in;
                pending_n = 1'b0;
            end else begin
                pending_n = 1'b1;
            end
        end else if (boundary && pending) begin
            disp_n    = shd;
            disp_dp_n = shd_dp;
            pending_n = 1'b0;
        end
    end

    // Output decode works on the next-state values so the registered
    // outputs line up with the cnt/idx they describe.
    always_comb begin
        lit = 1'b1;
`ifdef SEG_LZB_EN
        case (idx_n)
            2'd3:    lit = (disp_n[15:12] != 4'h0) || disp_dp_n[3];
            2'd2:    lit = (disp_n[15:8] != 8'h00) || (disp_dp_n[3:2] != 2'b00);
            2'd1:    lit = (disp_n[15:4] != 12'h000) || (disp_dp_n[3:1] != 3'b000);
            default: lit = 1'b1;
        endcase
`else
        lit = 1'b1;
`endif
        an_n         = 4'b1111;
        seg_n        = 7'b1111111;
        dp_n         = 1'b1;
        frame_done_n = (idx_n == 2'd3) && (cnt_n == LAST);
        if (!blank && (cnt_n != '0) && lit) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = hex_to_seg(disp_n[{idx_n, 2'b00} +: 4]);
            dp_n  = ~disp_dp_n[idx_n];
        end
    end

    // State and output registers; reset aborts the scan and drops any
    // pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0000;
            disp_dp    <= 4'h0;
            shd        <= 16'h0000;
            shd_dp     <= 4'h0;
            pending    <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            idx        <= idx_n;
            disp       <= disp_n;
            disp_dp    <= disp_dp_n;
            shd        <= shd_n;
            shd_dp     <= shd_dp_n;
            pending    <= pending_n;
            an         <= an_n;
            seg        <= seg_n;
            dp         <= dp_n;
            frame_done <= frame_done_n;
        end
    end

    assign busy = pending;

endmodule
